// File: rtl/cnn_ctrl_pkg.sv
// Shared types and defaults for the CNN layer control path: sequencer states,
// layer/timeout defaults and the saturating counter helper.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CFG,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } seq_state_t;

    localparam int DEF_N_LAYERS = 4;
    localparam int DEF_TIMEOUT  = 4096;
    localparam int DROP_W       = 8;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer watchdog: counts enabled cycles while a layer runs and flags the
// cycle in which the count reaches TIMEOUT.
module layer_watchdog
    import cnn_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    // High during the TIMEOUT-th enabled cycle, so a layer gets exactly TIMEOUT run cycles.
    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Frame-level sequencer: walks the chained layer iterators in order, waiting for
// each layer's configuration, launching it and supervising it with a watchdog.
module layer_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int N_LAYERS = DEF_N_LAYERS,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic                        frame_start,
    input  logic [N_LAYERS-1:0]         layer_cfg_ready,
    input  logic [N_LAYERS-1:0]         layer_ready,
    output logic [N_LAYERS-1:0]         layer_going,
    output logic [$clog2(N_LAYERS)-1:0] cur_layer,
    output logic                        busy,
    output logic                        frame_done,
    input  logic                        err_clr,
    output logic                        timeout_err,
    output logic [DROP_W-1:0]           frames_dropped
);

    localparam int            LW   = $clog2(N_LAYERS);
    localparam logic [LW-1:0] LAST = LW'(N_LAYERS - 1);

    seq_state_t state;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;

    assign wd_clear  = clk_en && (state == ST_LAUNCH);
    assign wd_enable = clk_en && (state == ST_RUN);

    layer_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            layer_going    <= '0;
            cur_layer      <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            timeout_err    <= 1'b0;
            frames_dropped <= '0;
        end else if (clk_en) begin
            layer_going <= '0;
            frame_done  <= 1'b0;

            // Clear first so that a timeout in the same cycle overrides it.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            if (frame_start && (state != ST_IDLE)) begin
                frames_dropped <= sat_inc(frames_dropped);
            end

            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state     <= ST_WAIT_CFG;
                        cur_layer <= '0;
                        busy      <= 1'b1;
                    end
                end

                ST_WAIT_CFG: begin
                    if (layer_cfg_ready[cur_layer]) begin
                        state       <= ST_LAUNCH;
                        layer_going <= N_LAYERS'(1) << cur_layer;
                    end
                end

                ST_LAUNCH: begin
                    state <= ST_RUN;
                end

                ST_RUN: begin
                    // Completion is tested before expiry so it wins a tie.
                    if (layer_ready[cur_layer]) begin
                        if (cur_layer == LAST) begin
                            state      <= ST_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state     <= ST_WAIT_CFG;
                            cur_layer <= cur_layer + 1'b1;
                        end
                    end else if (wd_expired) begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a frame-level model predicts the event
// stream (launches, completion or timeout) and a monitor checks it as it appears.
module tb_layer_sequencer;

    localparam int NL    = 4;
    localparam int TO    = 16;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en;
    logic          frame_start;
    logic          err_clr;
    logic [NL-1:0] layer_cfg_ready;
    logic [NL-1:0] resp_ready;
    logic [NL-1:0] spurious;
    logic [NL-1:0] layer_ready;
    logic [NL-1:0] layer_going;
    logic [1:0]    cur_layer;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic [7:0]    frames_dropped;

    assign layer_ready = resp_ready | spurious;

    always #5 clk = ~clk;

    layer_sequencer #(
        .N_LAYERS (NL),
        .TIMEOUT  (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .frame_start     (frame_start),
        .layer_cfg_ready (layer_cfg_ready),
        .layer_ready     (layer_ready),
        .layer_going     (layer_going),
        .cur_layer       (cur_layer),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_clr         (err_clr),
        .timeout_err     (timeout_err),
        .frames_dropped  (frames_dropped)
    );

    typedef enum int {EV_GO, EV_DONE, EV_TMO} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       layer;
    } ev_t;

    ev_t exp_q[$];
    int  delay_tab[NL];
    int  checks    = 0;
    int  errors    = 0;
    int  ecnt      = 0;
    int  done_seen = 0;
    bit  last_dis  = 1'b0;
    bit  en_random = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input ev_kind_t kind, input int layer);
        ev_t e;
        e.kind  = kind;
        e.layer = layer;
        exp_q.push_back(e);
    endfunction

    // Frame model: layers launch in order; a layer whose response comes later than
    // TIMEOUT run cycles aborts the frame, otherwise the frame completes.
    function automatic void build_expect();
        for (int i = 0; i < NL; i++) begin
            push_ev(EV_GO, i);
            if (delay_tab[i] > TO) begin
                push_ev(EV_TMO, i);
                return;
            end
        end
        push_ev(EV_DONE, NL - 1);
    endfunction

    function automatic bit expects_timeout();
        for (int i = 0; i < NL; i++) begin
            if (delay_tab[i] > TO) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Enabled-edge counter shared by the monitor and the stimulus.
    initial begin
        forever begin
            @(posedge clk);
            last_dis = !clk_en;
            if (clk_en && rst_n) ecnt++;
        end
    end

    initial begin
        clk_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            clk_en = en_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected events, checks hold on disabled cycles, and plays the
    // layer iterators by answering each launch after its programmed delay.
    initial begin : monitor
        logic [16:0] snap;
        logic [16:0] prev_snap;
        logic        prev_err;
        bit          have_prev;
        bit          resp_active;
        int          resp_target;
        int          resp_idx;
        int          go_ecnt;
        ev_t         e;
        have_prev   = 1'b0;
        prev_err    = 1'b0;
        resp_active = 1'b0;
        resp_target = 0;
        resp_idx    = 0;
        go_ecnt     = 0;
        prev_snap   = '0;
        resp_ready  = '0;
        forever begin
            @(negedge clk);
            snap = {layer_going, cur_layer, busy, frame_done, timeout_err, frames_dropped};
            if (!rst_n) begin
                have_prev   = 1'b0;
                prev_err    = 1'b0;
                resp_active = 1'b0;
                resp_ready  = '0;
            end else begin
                if (have_prev && last_dis)
                    chk("hold_on_disabled", 32'(snap), 32'(prev_snap));
                if (clk_en && (layer_going != '0)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_going", 32'(layer_going), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("going_event_kind", e.kind, EV_GO);
                        chk("going_onehot", 32'(layer_going), 32'd1 << e.layer);
                        go_ecnt     = ecnt;
                        resp_active = 1'b1;
                        resp_idx    = e.layer;
                        resp_target = ecnt + 1 + delay_tab[e.layer];
                    end
                end
                if (clk_en && frame_done) begin
                    done_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame_done", 32'(frame_done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_event_kind", e.kind, EV_DONE);
                    end
                end
                if (timeout_err && !prev_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_timeout", 32'(timeout_err), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("timeout_event_kind", e.kind, EV_TMO);
                        chk("timeout_latency", ecnt - go_ecnt, TO + 1);
                    end
                end
                resp_ready = (resp_active && clk_en && (ecnt + 1 == resp_target))
                           ? (NL'(1) << resp_idx) : '0;
                prev_err  = timeout_err;
                prev_snap = snap;
                have_prev = 1'b1;
            end
        end
    end

    task automatic issue_frame();
        build_expect();
        @(posedge clk);
        #1 frame_start = 1'b1;
        do @(posedge clk); while (!clk_en);
        #1 frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        int e0;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("frame_events_pending", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        e0 = ecnt;
        n  = 0;
        while ((ecnt < e0 + 2) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_layer(input int l, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((cur_layer == 2'(l)) && busy) && (n < budget));
        if (!((cur_layer == 2'(l)) && busy)) chk("wait_layer_reached", 32'(cur_layer), l);
    endtask

    task automatic wait_go(input logic [NL-1:0] mask, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((layer_going != mask) && (n < budget));
        if (layer_going != mask) chk("wait_going_seen", 32'(layer_going), 32'(mask));
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        do @(posedge clk); while (!clk_en);
        #1 err_clr = 1'b0;
    endtask

    initial begin : stimulus
        int  saved_done;
        bit  tmo;
        rst_n           = 1'b1;
        frame_start     = 1'b0;
        err_clr         = 1'b0;
        layer_cfg_ready = '1;
        spurious        = '0;
        for (int i = 0; i < NL; i++) delay_tab[i] = 10;

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_going", 32'(layer_going), 32'd0);
        chk("reset_ctrl", 32'({cur_layer, busy, frame_done}), 32'd0);
        chk("reset_err", 32'(timeout_err), 32'd0);
        chk("reset_dropped", 32'(frames_dropped), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Nominal frame with launch latency.
        issue_frame();
        @(negedge clk);
        chk("latency_wait_cfg", 32'({layer_going, busy}), 32'({4'b0000, 1'b1}));
        @(negedge clk);
        chk("latency_going0", 32'(layer_going), 32'b0001);
        wait_idle(2000);
        chk("nominal_done_count", done_seen, 1);
        chk("nominal_busy_after", 32'(busy), 32'd0);
        chk("nominal_no_err", 32'(timeout_err), 32'd0);

        // Configuration stall on layer 2.
        for (int i = 0; i < NL; i++) delay_tab[i] = 5;
        layer_cfg_ready = 4'b1011;
        issue_frame();
        wait_layer(2, 500);
        repeat (50) begin
            @(negedge clk);
            chk("stall_hold", 32'({layer_going, cur_layer, busy, timeout_err}),
                32'({4'b0000, 2'd2, 1'b1, 1'b0}));
        end
        layer_cfg_ready = '1;
        wait_idle(2000);
        chk("stall_done_count", done_seen, 2);

        // Layer 1 never answers.
        delay_tab[0] = 10;
        delay_tab[1] = NEVER;
        issue_frame();
        wait_idle(2000);
        chk("tmo_err_set", 32'(timeout_err), 32'd1);
        chk("tmo_busy_low", 32'(busy), 32'd0);
        chk("tmo_no_done", done_seen, 2);
        repeat (20) @(negedge clk);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        pulse_err_clr();
        @(negedge clk);
        chk("tmo_cleared", 32'(timeout_err), 32'd0);

        // Timeout while err_clr is held: the flag must still appear.
        err_clr = 1'b1;
        issue_frame();
        wait_idle(2000);
        chk("tmo_setwin_cleared_later", 32'(timeout_err), 32'd0);
        err_clr = 1'b0;

        // Spurious layer_ready and dropped frame_start while busy.
        delay_tab[0] = 12;
        for (int i = 1; i < NL; i++) delay_tab[i] = 5;
        layer_cfg_ready = 4'b1101;
        issue_frame();
        repeat (4) @(negedge clk);
        spurious = 4'b1000;
        repeat (5) @(negedge clk);
        spurious = '0;
        @(negedge clk);
        chk("spurious_ignored", 32'({cur_layer, busy, layer_going}), 32'({2'd0, 1'b1, 4'b0000}));
        wait_layer(1, 500);
        @(posedge clk);
        #1 frame_start = 1'b1;
        repeat (100) @(posedge clk);
        #1 frame_start = 1'b0;
        @(negedge clk);
        chk("dropped_100", 32'(frames_dropped), 32'd100);
        @(posedge clk);
        #1 frame_start = 1'b1;
        repeat (200) @(posedge clk);
        #1 frame_start = 1'b0;
        @(negedge clk);
        chk("dropped_saturated", 32'(frames_dropped), 32'd255);
        chk("dropped_no_restart", 32'({cur_layer, busy}), 32'({2'd1, 1'b1}));
        layer_cfg_ready = '1;
        wait_idle(2000);
        chk("drop_frame_done_count", done_seen, 3);

        // Randomised frames with 50% clock enable.
        en_random = 1'b1;
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < NL; i++) delay_tab[i] = $urandom_range(1, TO + 4);
            if (f % 5 == 0) delay_tab[$urandom_range(0, NL - 1)] = TO;
            layer_cfg_ready = NL'($urandom);
            tmo = expects_timeout();
            issue_frame();
            repeat ($urandom_range(0, 30)) @(negedge clk);
            layer_cfg_ready = '1;
            wait_idle(4000);
            chk("rand_idle", 32'(busy), 32'd0);
            if (tmo) begin
                chk("rand_tmo_set", 32'(timeout_err), 32'd1);
                pulse_err_clr();
                @(negedge clk);
                chk("rand_tmo_cleared", 32'(timeout_err), 32'd0);
            end else begin
                chk("rand_no_err", 32'(timeout_err), 32'd0);
            end
        end

        // Reset in the middle of layer 1's run.
        for (int i = 0; i < NL; i++) delay_tab[i] = 15;
        issue_frame();
        wait_go(4'b0010, 1000);
        repeat (4) @(negedge clk);
        saved_done = done_seen;
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrun_reset_outputs",
            32'({layer_going, cur_layer, busy, frame_done, timeout_err, frames_dropped}), 32'd0);
        repeat (3) @(posedge clk);
        chk("reset_held_outputs",
            32'({layer_going, cur_layer, busy, frame_done, timeout_err, frames_dropped}), 32'd0);
        #3 rst_n = 1'b1;
        en_random = 1'b0;
        repeat (40) @(negedge clk);
        chk("abandoned_no_done", done_seen, saved_done);
        chk("abandoned_idle", 32'(busy), 32'd0);

        for (int i = 0; i < NL; i++) delay_tab[i] = 10;
        issue_frame();
        wait_idle(2000);
        chk("post_reset_frame_done", done_seen, saved_done + 1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_time_limit: got t=%0t required completion earlier", $time);
        $fatal(1, "time limit reached");
    end

endmodule
